escritor_rtc: RTL
=================

ESCRITOR_RTC -- requirements
Module: escritor_rtc

Interface
REQ-001 Parameter T_ACT, default 4: cycles WR_n is held low per bus phase (legal 1..15).
REQ-002 Parameter T_GAP, default 2: cycles CS_n is held high between bus phases (legal 1..15).
REQ-003 reloj  in  1  system clock; all state changes on its rising edge.
REQ-004 resetM  in  1  reset, asynchronous, active-low.
REQ-005 IN_segh  in  8  BCD seconds to write (00..59).
REQ-006 IN_minh  in  8  BCD minutes to write (00..59).
REQ-007 IN_horah  in  8  BCD hours to write, format already applied by caller.
REQ-008 START  in  1  one-cycle write request.
REQ-009 BUSY  out  1  high while a write sequence is in progress.
REQ-010 DONE  out  1  one-cycle pulse at sequence completion.
REQ-011 CS_n, RD_n, WR_n  out  1 each  RTC bus strobes, active-low.
REQ-012 A_D  out  1  0 = address phase, 1 = data phase.
REQ-013 AD_out  out  8  multiplexed address/data value; AD_oe  out  1  bus drive enable.

Function
REQ-014 The block SHALL write register list: 0x21<-seg, 0x22<-min, 0x23<-hora, then commit 0xF1<-0x00, in that order.
REQ-015 On START while BUSY=0, IN_segh/IN_minh/IN_horah SHALL be latched that cycle; later input changes SHALL not affect the sequence.
REQ-016 START while BUSY=1 SHALL be ignored (no restart, no queueing).
REQ-017 FSM states: IDLE, SETUP, STROBE, HOLD, GAP; each register uses two passes (address, then data).
REQ-018 SETUP (1 cycle): CS_n=0, WR_n=1, AD_oe=1, A_D per phase, AD_out = address or data.
REQ-019 STROBE (T_ACT cycles): as SETUP with WR_n=0.
REQ-020 HOLD (1 cycle): WR_n=1, CS_n=0, AD_out/AD_oe/A_D unchanged.
REQ-021 GAP (T_GAP cycles): CS_n=1, AD_oe=0, AD_out=0x00.
REQ-022 After GAP of the data phase of 0xF1, FSM SHALL return to IDLE with DONE=1 for exactly that one cycle and BUSY=0.
REQ-023 BUSY SHALL rise the cycle after accepted START; total BUSY cycles = 8*(T_ACT+T_GAP+2) (64 at defaults).
REQ-024 RD_n SHALL be 1 at all times; WR_n SHALL never be 0 while CS_n=1.
REQ-025 AD_out and A_D SHALL not change while WR_n=0.

Reset
REQ-026 resetM=0 SHALL immediately force IDLE, CS_n=WR_n=RD_n=1, A_D=0, AD_out=0x00, AD_oe=0, BUSY=0, DONE=0, latched data=0x00.
REQ-027 Reset mid-sequence SHALL abort without DONE; the next START after release SHALL restart from register 0x21.

Configuration
REQ-028 Macro ESCRITURA_FECHA_EN defined: ports IN_dia, IN_mes, IN_anio (in, 8, BCD) SHALL exist and registers 0x24<-dia, 0x25<-mes, 0x26<-anio SHALL be written after 0x23 and before the commit, giving 14 passes (112 BUSY cycles at defaults).
REQ-029 Macro undefined: those ports and writes SHALL not exist; behaviour per REQ-014.

Structure
REQ-030 Package bloque_rtc_pkg SHALL hold register addresses (0x21..0x26, 0xF1), the FSM state enum and the pass-count constants.
REQ-031 Sub-module temporizador_fase SHALL provide the loadable down-counter for STROBE and GAP durations; FSM and register sequencing stay in escritor_rtc.

Verification
REQ-032 Reset then START with seg=0x45, min=0x30, hora=0x12 -> bus trace 21/45, 22/30, 23/12, F1/00 on address/data phases; DONE 64 cycles after BUSY rises.
REQ-033 Change inputs to 0x00 during BUSY -> written values remain 0x45/0x30/0x12.
REQ-034 Second START pulse at BUSY cycle 10 -> ignored; exactly one DONE, 8 WR_n pulses each T_ACT=4 cycles wide.
REQ-035 resetM=0 during data phase of 0x22 -> strobes high and AD_oe=0 same cycle; no DONE; next START writes from 0x21.
REQ-036 Parameters T_ACT=1, T_GAP=1 -> 32 BUSY cycles, protocol checkers REQ-024/025 pass.
REQ-037 With ESCRITURA_FECHA_EN, dia=0x15, mes=0x04, anio=0x17 -> additional writes 24/15, 25/04, 26/17 before F1/00; 112 BUSY cycles.

Source files
------------

// File: rtl/bloque_rtc_pkg.sv
// Shared definitions for the RTC register writer: register map, FSM states,
// pass counts and the latched time payload.
// Optional feature macro: ESCRITURA_FECHA_EN (adds day/month/year registers).
package bloque_rtc_pkg;

  localparam logic [7:0] ADDR_SEG    = 8'h21;
  localparam logic [7:0] ADDR_MIN    = 8'h22;
  localparam logic [7:0] ADDR_HORA   = 8'h23;
  localparam logic [7:0] ADDR_DIA    = 8'h24;
  localparam logic [7:0] ADDR_MES    = 8'h25;
  localparam logic [7:0] ADDR_ANIO   = 8'h26;
  localparam logic [7:0] ADDR_COMMIT = 8'hF1;
  localparam logic [7:0] DATA_COMMIT = 8'h00;

`ifdef ESCRITURA_FECHA_EN
  localparam int unsigned NUM_REGS = 7;
`else
  localparam int unsigned NUM_REGS = 4;
`endif
  // Each register takes an address pass followed by a data pass
  localparam int unsigned NUM_PASSES = 2 * NUM_REGS;
  localparam int unsigned PASS_W     = 4;
  localparam int unsigned IDX_W      = PASS_W - 1;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } estado_t;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] min;
    logic [7:0] hora;
`ifdef ESCRITURA_FECHA_EN
    logic [7:0] dia;
    logic [7:0] mes;
    logic [7:0] anio;
`endif
  } tiempo_t;

  // Register address written by register slot idx; last slot is the commit
  function automatic logic [7:0] reg_addr(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    reg_addr = ADDR_SEG;
      3'd1:    reg_addr = ADDR_MIN;
      3'd2:    reg_addr = ADDR_HORA;
`ifdef ESCRITURA_FECHA_EN
      3'd3:    reg_addr = ADDR_DIA;
      3'd4:    reg_addr = ADDR_MES;
      3'd5:    reg_addr = ADDR_ANIO;
`endif
      default: reg_addr = ADDR_COMMIT;
    endcase
  endfunction

endpackage

// File: rtl/escritor_rtc_if.sv
// Multiplexed RTC write bus: active-low strobes plus address/data lines.
interface escritor_rtc_if;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A_D;
  logic       AD_oe;
  logic [7:0] AD_out;

  modport master (output CS_n, RD_n, WR_n, A_D, AD_oe, AD_out);
  modport slave  (input  CS_n, RD_n, WR_n, A_D, AD_oe, AD_out);
endinterface

// File: rtl/escritor_rtc_temporizador_fase.sv
// Loadable down-counter timing the STROBE and GAP phases.
module temporizador_fase
  import bloque_rtc_pkg::*;
(
  input  logic             reloj,
  input  logic             resetM,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM)              cnt_q <= '0;
    else if (load)            cnt_q <= load_val;
    else if (cnt_q != '0)     cnt_q <= cnt_q - CNT_W'(1);
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/escritor_rtc.sv
// Writes the latched time (and optionally date) into an RTC over a
// multiplexed address/data bus, finishing with a commit write.
// Optional feature macro: ESCRITURA_FECHA_EN (adds IN_dia/IN_mes/IN_anio).
module escritor_rtc
  import bloque_rtc_pkg::*;
#(
  parameter int unsigned T_ACT = 4,
  parameter int unsigned T_GAP = 2
)(
  input  logic       reloj,
  input  logic       resetM,
  input  logic [7:0] IN_segh,
  input  logic [7:0] IN_minh,
  input  logic [7:0] IN_horah,
`ifdef ESCRITURA_FECHA_EN
  input  logic [7:0] IN_dia,
  input  logic [7:0] IN_mes,
  input  logic [7:0] IN_anio,
`endif
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  escritor_rtc_if.master bus
);

  estado_t          state_q, state_n;
  logic [PASS_W-1:0] pass_q, pass_n;
  logic [IDX_W-1:0] idx_n;
  tiempo_t          dat_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero_c;
  logic [7:0]       dato_c, val_c;
  logic             busy_n, done_n, cs_n_n, wr_n_n, a_d_n, ad_oe_n;
  logic [7:0]       ad_out_n;

  temporizador_fase u_temporizador (
    .reloj    (reloj),
    .resetM   (resetM),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero_c   (cnt_zero_c)
  );

  // Capture the payload only when a request is accepted
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      dat_q <= '0;
    end else if (state_q == ST_IDLE && START) begin
      dat_q.seg  <= IN_segh;
      dat_q.min  <= IN_minh;
      dat_q.hora <= IN_horah;
`ifdef ESCRITURA_FECHA_EN
      dat_q.dia  <= IN_dia;
      dat_q.mes  <= IN_mes;
      dat_q.anio <= IN_anio;
`endif
    end
  end

  // State, pass index and registered bus outputs
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state_q    <= ST_IDLE;
      pass_q     <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      bus.CS_n   <= 1'b1;
      bus.RD_n   <= 1'b1;
      bus.WR_n   <= 1'b1;
      bus.A_D    <= 1'b0;
      bus.AD_oe  <= 1'b0;
      bus.AD_out <= 8'h00;
    end else begin
      state_q    <= state_n;
      pass_q     <= pass_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
      bus.CS_n   <= cs_n_n;
      bus.RD_n   <= 1'b1;
      bus.WR_n   <= wr_n_n;
      bus.A_D    <= a_d_n;
      bus.AD_oe  <= ad_oe_n;
      bus.AD_out <= ad_out_n;
    end
  end

  // Next state, then outputs decoded from the next state so they register cleanly
  always_comb begin
    state_n  = state_q;
    pass_n   = pass_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    done_n   = 1'b0;
    cs_n_n   = 1'b1;
    wr_n_n   = 1'b1;
    a_d_n    = 1'b0;
    ad_oe_n  = 1'b0;
    ad_out_n = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_n = ST_SETUP;
          pass_n  = '0;
        end
      end
      ST_SETUP: begin
        state_n  = ST_STROBE;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(T_ACT - 1);
      end
      ST_STROBE: begin
        if (cnt_zero_c) state_n = ST_HOLD;
      end
      ST_HOLD: begin
        state_n  = ST_GAP;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(T_GAP - 1);
      end
      ST_GAP: begin
        if (cnt_zero_c) begin
          if (pass_q == PASS_W'(NUM_PASSES - 1)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_SETUP;
            pass_n  = PASS_W'(pass_q + PASS_W'(1));
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    idx_n = pass_n[PASS_W-1:1];
    case (idx_n)
      3'd0:    dato_c = dat_q.seg;
      3'd1:    dato_c = dat_q.min;
      3'd2:    dato_c = dat_q.hora;
`ifdef ESCRITURA_FECHA_EN
      3'd3:    dato_c = dat_q.dia;
      3'd4:    dato_c = dat_q.mes;
      3'd5:    dato_c = dat_q.anio;
`endif
      default: dato_c = DATA_COMMIT;
    endcase
    val_c  = pass_n[0] ? dato_c : reg_addr(idx_n);
    busy_n = (state_n != ST_IDLE);

    case (state_n)
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        cs_n_n   = 1'b0;
        wr_n_n   = (state_n != ST_STROBE);
        a_d_n    = pass_n[0];
        ad_oe_n  = 1'b1;
        ad_out_n = val_c;
      end
      ST_GAP:  a_d_n = pass_n[0];
      default: ;
    endcase
  end

endmodule
